ps2_mouse_init_ctrl: RTL and testbench

Host-side initialisation sequencer for the PS/2 mouse interface. It drives the byte transmitter (command path) and monitors the byte receiver (response path) to run the bring-up sequence: reset (0xFF), then ACK, BAT 0xAA and ID 0x00, then enable streaming (0xF4) and ACK. It handles resend requests, errors and timeouts with bounded retries. Once streaming, it asserts stream_enable so the packet decoder may consume received bytes.

---
 rtl/ps2_mouse_init_ctrl.sv | 112 +++++++++++
 tb/tb_ps2_mouse_init_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_init_ctrl.sv
// ps2_mouse_init_ctrl: PS/2 mouse bring-up sequencer (reset, BAT, ID, enable streaming)
// with resend/timeout handling and bounded retries.
module ps2_mouse_init_ctrl #(
  parameter int ACK_TIMEOUT_CYC = 1000000,
  parameter int BAT_TIMEOUT_CYC = 37500000,
  parameter int MAX_RETRY       = 3,
  parameter int TMR_W           = 26
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       tx_error,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       stream_enable,
  output logic       busy,
  output logic       fail,
  output logic [2:0] err_code,
  output logic [1:0] retry_cnt
);
  typedef enum logic [3:0] {
    IDLE, SEND_RST, W_ACK_RST, W_BAT, W_ID, SEND_EN, W_ACK_EN, STREAM, FAIL
  } state_t;
  localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] BAT_LAST  = TMR_W'(BAT_TIMEOUT_CYC - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);
  state_t           state, nxt, rt_to;
  logic [TMR_W-1:0] timer;
  logic [1:0]       retry_n;
  logic [2:0]       err_n, rt_err;
  logic             waiting, timeout, rt;
  assign waiting = state inside {W_ACK_RST, W_BAT, W_ID, W_ACK_EN};
  assign timeout = waiting && timer == (state == W_BAT ? BAT_LAST : ACK_LAST);
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      retry_cnt <= '0;
      err_code  <= '0;
    end else begin
      state     <= nxt;
      timer     <= (nxt != state || !waiting) ? '0 : timer + TMR_W'(1);
      retry_cnt <= retry_n;
      err_code  <= err_n;
    end
  end
  // Terminating rx events take priority over a coincident timeout; tx_error beats rx.
  always_comb begin
    nxt     = state;
    retry_n = retry_cnt;
    err_n   = err_code;
    rt      = 1'b0;
    rt_to   = SEND_RST;
    rt_err  = 3'd1;
    case (state)
      IDLE, STREAM, FAIL: if (start) begin
        nxt     = SEND_RST;
        retry_n = '0;
        err_n   = '0;
      end
      SEND_RST: if (tx_ready) nxt = W_ACK_RST;
      SEND_EN:  if (tx_ready) nxt = W_ACK_EN;
      W_ACK_RST, W_ACK_EN: begin
        if (tx_error || (rx_valid && rx_byte == 8'hFE)) begin
          rt     = 1'b1;
          rt_to  = state == W_ACK_RST ? SEND_RST : SEND_EN;
          rt_err = 3'd6;
        end else if (rx_valid && rx_byte == 8'hFA) begin
          nxt = state == W_ACK_RST ? W_BAT : STREAM;
        end else if (rx_valid && rx_byte == 8'hFC) begin
          nxt   = FAIL;
          err_n = 3'd4;
        end else if (timeout) begin
          rt = 1'b1;
        end
      end
      W_BAT: begin
        if (rx_valid && rx_byte == 8'hAA) begin
          nxt = W_ID;
        end else if (rx_valid && rx_byte == 8'hFC) begin
          nxt   = FAIL;
          err_n = 3'd3;
        end else if (timeout) begin
          rt     = 1'b1;
          rt_err = 3'd2;
        end
      end
      W_ID: begin
        if (rx_valid) begin
          nxt   = rx_byte == 8'h00 ? SEND_EN : FAIL;
          err_n = rx_byte == 8'h00 ? err_code : 3'd5;
        end else if (timeout) begin
          rt = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
    if (rt) begin
      nxt     = retry_cnt < RETRY_MAX ? rt_to : FAIL;
      retry_n = retry_cnt < RETRY_MAX ? retry_cnt + 2'd1 : retry_cnt;
      err_n   = retry_cnt < RETRY_MAX ? err_code : rt_err;
    end
  end
  assign tx_valid      = state == SEND_RST || state == SEND_EN;
  assign tx_byte       = state == SEND_RST ? 8'hFF : state == SEND_EN ? 8'hF4 : 8'h00;
  assign busy          = !(state inside {IDLE, STREAM, FAIL});
  assign stream_enable = state == STREAM;
  assign fail          = state == FAIL;
endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// tb_ps2_mouse_init_ctrl: table-driven vectors plus timeout, coincidence and reset sequences.
module tb_ps2_mouse_init_ctrl;
  logic       clk_50 = 1'b0;
  logic       reset, start, tx_ready, tx_error, rx_valid;
  logic [7:0] rx_byte, tx_byte;
  logic       tx_valid, stream_enable, busy, fail;
  logic [2:0] err_code;
  logic [1:0] retry_cnt;
  logic [16:0] act;
  int tests = 0;
  int fails = 0;
  typedef struct packed {
    logic        st, rdy, terr, rv;
    logic [7:0]  rb;
    logic [16:0] exp;
  } vec_t;
  vec_t tbl[38];
  int   n = 0;
  always #5 clk_50 = ~clk_50;
  ps2_mouse_init_ctrl #(
    .ACK_TIMEOUT_CYC(50), .BAT_TIMEOUT_CYC(200), .MAX_RETRY(3), .TMR_W(26)
  ) dut (
    .clk_50(clk_50), .reset(reset), .start(start),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_error(tx_error),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .stream_enable(stream_enable), .busy(busy), .fail(fail),
    .err_code(err_code), .retry_cnt(retry_cnt)
  );
  assign act = {tx_valid, tx_byte, stream_enable, busy, fail, err_code, retry_cnt};
  // expected output words: {tx_valid, tx_byte, stream_enable, busy, fail, err_code, retry_cnt}
  function automatic logic [16:0] e_sr(input logic [1:0] r); return {1'b1, 8'hFF, 3'b010, 3'd0, r}; endfunction
  function automatic logic [16:0] e_se(input logic [1:0] r); return {1'b1, 8'hF4, 3'b010, 3'd0, r}; endfunction
  function automatic logic [16:0] e_w(input logic [1:0] r);  return {1'b0, 8'h00, 3'b010, 3'd0, r}; endfunction
  function automatic logic [16:0] e_st(input logic [1:0] r); return {1'b0, 8'h00, 3'b100, 3'd0, r}; endfunction
  function automatic logic [16:0] e_fl(input logic [2:0] e, input logic [1:0] r);
    return {1'b0, 8'h00, 3'b001, e, r};
  endfunction
  task automatic add(input logic st, rdy, terr, rv, input logic [7:0] rb, input logic [16:0] exp);
    tbl[n] = '{st, rdy, terr, rv, rb, exp};
    n++;
  endtask
  task automatic check(input string name, input logic [16:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic st, rdy, terr, rv, input logic [7:0] rb);
    @(negedge clk_50);
    start = st; tx_ready = rdy; tx_error = terr; rx_valid = rv; rx_byte = rb;
    @(posedge clk_50);
    #1;
  endtask
  task automatic idle(); step(0, 0, 0, 0, 8'h00); endtask
  task automatic do_reset();
    reset = 1'b1;
    idle();
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1; start = 0; tx_ready = 0; tx_error = 0; rx_valid = 0; rx_byte = 0;
    // normal bring-up, STREAM ignores rx
    add(1, 0, 0, 0, 8'h00, e_sr(0));
    add(0, 0, 0, 0, 8'h00, e_sr(0));
    add(0, 1, 0, 0, 8'h00, e_w(0));
    add(0, 0, 0, 1, 8'hFA, e_w(0));
    add(0, 0, 0, 1, 8'h55, e_w(0));
    add(0, 0, 0, 1, 8'hAA, e_w(0));
    add(0, 0, 0, 1, 8'h00, e_se(0));
    add(0, 1, 0, 0, 8'h00, e_w(0));
    add(0, 0, 0, 1, 8'hFA, e_st(0));
    add(0, 0, 0, 1, 8'hFE, e_st(0));
    // restart from STREAM, resend of 0xF4
    add(1, 0, 0, 0, 8'h00, e_sr(0));
    add(0, 1, 0, 0, 8'h00, e_w(0));
    add(0, 0, 0, 1, 8'hFA, e_w(0));
    add(0, 0, 0, 1, 8'hAA, e_w(0));
    add(0, 0, 0, 1, 8'h00, e_se(0));
    add(0, 1, 0, 0, 8'h00, e_w(0));
    add(0, 0, 0, 1, 8'hFE, e_se(1));
    add(0, 1, 0, 0, 8'h00, e_w(1));
    add(0, 0, 0, 1, 8'hFA, e_st(1));
    // BAT failure, held in FAIL
    add(1, 0, 0, 0, 8'h00, e_sr(0));
    add(0, 1, 0, 0, 8'h00, e_w(0));
    add(0, 0, 0, 1, 8'hFA, e_w(0));
    add(0, 0, 0, 1, 8'hFC, e_fl(3, 0));
    add(0, 0, 0, 1, 8'hFA, e_fl(3, 0));
    // bad ID
    add(1, 0, 0, 0, 8'h00, e_sr(0));
    add(0, 1, 0, 0, 8'h00, e_w(0));
    add(0, 0, 0, 1, 8'hFA, e_w(0));
    add(0, 0, 0, 1, 8'hAA, e_w(0));
    add(0, 0, 0, 1, 8'h03, e_fl(5, 0));
    // tx_error beats coincident FA, then device error FC
    add(1, 0, 0, 0, 8'h00, e_sr(0));
    add(0, 1, 0, 0, 8'h00, e_w(0));
    add(0, 0, 1, 1, 8'hFA, e_sr(1));
    add(0, 1, 0, 0, 8'h00, e_w(1));
    add(0, 0, 0, 1, 8'hFC, e_fl(4, 1));
    // start / tx_error while busy are ignored
    add(1, 0, 0, 0, 8'h00, e_sr(0));
    add(1, 0, 1, 0, 8'h00, e_sr(0));
    add(0, 1, 0, 0, 8'h00, e_w(0));
    add(1, 1, 0, 0, 8'h00, e_w(0));
    idle();
    do_reset();
    check("reset_state", 17'h0);
    for (int i = 0; i < n; i++) begin
      step(tbl[i].st, tbl[i].rdy, tbl[i].terr, tbl[i].rv, tbl[i].rb);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end
    // four consecutive ACK timeouts, 50 cycles each
    do_reset();
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    for (int r = 0; r < 4; r++) begin
      for (int k = 1; k <= 50; k++) begin
        idle();
        if (k == 49) check($sformatf("to%0d_wait", r), e_w(2'(r)));
        if (k == 50) check($sformatf("to%0d_fire", r), r < 3 ? e_sr(2'(r + 1)) : e_fl(1, 3));
      end
      if (r < 3) step(0, 1, 0, 0, 8'h00);
    end
    // FA on the timeout cycle wins; W_BAT then times out after 200 cycles
    do_reset();
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    for (int k = 1; k < 50; k++) idle();
    step(0, 0, 0, 1, 8'hFA);
    check("fa_on_timeout", e_w(0));
    for (int k = 1; k <= 200; k++) begin
      idle();
      if (k == 199) check("bat_wait", e_w(0));
      if (k == 200) check("bat_timeout", e_sr(1));
    end
    // reset while SEND_EN is requesting
    do_reset();
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 1, 8'hFA);
    step(0, 0, 0, 1, 8'hAA);
    step(0, 0, 0, 1, 8'h00);
    check("pre_reset_send_en", e_se(0));
    reset = 1'b1;
    step(0, 1, 0, 0, 8'h00);
    check("mid_reset", 17'h0);
    reset = 1'b0;
    idle();
    check("post_reset_idle", 17'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
